// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// New content is double-buffered and is applied only at frame boundaries, so a frame is never torn.
module seg7_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     PRE_ONE  = PW'(1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  logic [1:0]          rst_sync_r;
  logic                run_s;
  logic [PW-1:0]       presc_r;
  logic [IW-1:0]       idx_r;
  logic                tick_s;
  logic                boundary_s;
  logic                frame_start_r;

  logic                pend_flag_r;
  logic [4*DIGITS-1:0] pend_digits_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic [DIGITS-1:0]   pend_blank_r;
  logic                pend_lz_r;
  logic [4*DIGITS-1:0] act_digits_r;
  logic [DIGITS-1:0]   act_dp_r;
  logic [DIGITS-1:0]   act_blank_r;
  logic                act_lz_r;

  logic [3:0]          cur_nib_s;
  logic                cur_blank_s;
  logic                sup_s;
  logic                zero_run_s;
  logic [6:0]          seg_next_s;
  logic                dp_next_s;
  logic [DIGITS-1:0]   an_next_s;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0001100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b1110010;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_r <= 2'b00;
    else        rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign run_s      = rst_sync_r[1];
  assign tick_s     = (presc_r == PRE_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

  // Slot prescaler and digit index; held at zero until reset release has been synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= '0;
      idx_r         <= '0;
      frame_start_r <= 1'b0;
    end else if (!run_s) begin
      presc_r       <= '0;
      idx_r         <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= boundary_s;
      if (tick_s) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_ONE;
      end else begin
        presc_r <= presc_r + PRE_ONE;
      end
    end
  end

  // Pending/active double buffer: a load on the boundary edge still promotes the older pending copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_flag_r   <= 1'b0;
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      pend_blank_r  <= '1;
      pend_lz_r     <= 1'b0;
      act_digits_r  <= '0;
      act_dp_r      <= '0;
      act_blank_r   <= '1;
      act_lz_r      <= 1'b0;
    end else if (!run_s) begin
      pend_flag_r   <= 1'b0;
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      pend_blank_r  <= '1;
      pend_lz_r     <= 1'b0;
      act_digits_r  <= '0;
      act_dp_r      <= '0;
      act_blank_r   <= '1;
      act_lz_r      <= 1'b0;
    end else begin
      if (boundary_s && pend_flag_r) begin
        act_digits_r <= pend_digits_r;
        act_dp_r     <= pend_dp_r;
        act_blank_r  <= pend_blank_r;
        act_lz_r     <= pend_lz_r;
      end
      if (load) begin
        pend_flag_r   <= 1'b1;
        pend_digits_r <= digits_in;
        pend_dp_r     <= dp_in;
        pend_blank_r  <= blank_in;
        pend_lz_r     <= lz_en;
      end else if (boundary_s) begin
        pend_flag_r <= 1'b0;
      end
    end
  end

  // Next segment/anode pattern for the current slot, including leading-zero suppression.
  always_comb begin
    cur_nib_s   = act_digits_r[{idx_r, 2'b00} +: 4];
    cur_blank_s = act_blank_r[idx_r];
    zero_run_s  = 1'b1;
    sup_s       = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (act_digits_r[4*i +: 4] == 4'h0);
      if ((i > 0) && zero_run_s && act_lz_r && (IW'(i) == idx_r)) begin
        sup_s = 1'b1;
      end else begin
        sup_s = sup_s;
      end
    end
    if (cur_blank_s || sup_s) begin
      seg_next_s = 7'b1111111;
    end else begin
      seg_next_s = glyph(cur_nib_s);
    end
    if (cur_blank_s) begin
      dp_next_s = 1'b1;
    end else begin
      dp_next_s = ~act_dp_r[idx_r];
    end
    if (cur_blank_s || (presc_r == '0)) begin
      an_next_s = '1;
    end else begin
      an_next_s = ~(AN_ONE << idx_r);
    end
  end

  // Registered display outputs, dark during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
      an_r  <= '1;
    end else if (!run_s) begin
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
      an_r  <= '1;
    end else begin
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
      an_r  <= an_next_s;
    end
  end

  assign seg         = seg_r;
  assign dp          = dp_r;
  assign an          = an_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux at DIGITS=4, SCAN_DIV=4: each expected frame is queued
// when its stimulus is applied and compared cycle by cycle as the display scans.
module tb_seg7_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [15:0] cur_d = 16'h0000;
  logic [3:0]  cur_p = 4'h0;
  logic [3:0]  cur_b = 4'hF;
  logic        cur_l = 1'b0;

  seg7_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b1110010;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  4'hF: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One frame as seen on the outputs: four slots of four cycles, the first cycle of each a guard.
  function automatic void push_frame(input logic [15:0] d, input logic [3:0] p,
                                     input logic [3:0] b, input logic l);
    for (int k = 0; k < 4; k++) begin
      logic zero;
      logic [6:0] s;
      logic pd;
      logic [3:0] a;
      zero = 1'b1;
      for (int j = k; j < 4; j++) zero = zero && (d[4*j +: 4] == 4'h0);
      s  = (b[k] || (l && k > 0 && zero)) ? 7'b1111111 : ref_glyph(d[4*k +: 4]);
      pd = b[k] ? 1'b1 : ~p[k];
      for (int c = 0; c < 4; c++) begin
        a = (b[k] || c == 0) ? 4'b1111 : ~(4'b0001 << k);
        exp_q.push_back({s, pd, a});
      end
    end
  endfunction

  task automatic wait_fs(input string name);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s wait_frame_start: no frame_start within 64 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({seg, dp, an, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got seg=%b dp=%b an=%b fs=%b expected 1111111 1 1111 0",
               seg, dp, an, frame_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int last = -1;
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'b1111) begin
        errors++;
        $display("FAIL idle_an cycle=%0d got %b expected 1111", k, an);
      end
      if (frame_start === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          checks++;
          if (k - last != 16) begin
            errors++;
            $display("FAIL idle_fs_period got %0d expected 16", k - last);
          end
        end
        last = k;
      end
    end
    checks++;
    if (pulses < 2) begin
      errors++;
      $display("FAIL idle_fs_count got %0d expected >=2", pulses);
    end
  endtask

  // Load at a frame start: the following frame still shows old content, the one after shows new.
  task automatic test_load(input string name, input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] b, input logic l);
    logic [11:0] e;
    wait_fs(name);
    digits_in = d; dp_in = p; blank_in = b; lz_en = l; load = 1'b1;
    push_frame(cur_d, cur_p, cur_b, cur_l);
    push_frame(d, p, b, l);
    cur_d = d; cur_p = p; cur_b = b; cur_l = l;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      load = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({seg, dp, an} !== e) begin
        errors++;
        $display("FAIL %s cycle=%0d got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                 name, k, seg, dp, an, e[11:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_two_loads();
    logic [11:0] e;
    wait_fs("two_loads");
    digits_in = 16'h1111; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
    push_frame(cur_d, cur_p, cur_b, cur_l);
    push_frame(16'h2222, 4'h0, 4'h0, 1'b0);
    cur_d = 16'h2222; cur_p = 4'h0; cur_b = 4'h0; cur_l = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 4) begin
        digits_in = 16'h2222; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      e = exp_q.pop_front();
      checks++;
      if ({seg, dp, an} !== e) begin
        errors++;
        $display("FAIL two_loads cycle=%0d got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                 k, seg, dp, an, e[11:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [11:0] e;
    wait_fs("boundary_load");
    digits_in = 16'h3456; dp_in = 4'b0001; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
    push_frame(cur_d, cur_p, cur_b, cur_l);
    push_frame(16'h3456, 4'b0001, 4'h0, 1'b0);
    push_frame(16'h789C, 4'b1000, 4'b0010, 1'b0);
    cur_d = 16'h789C; cur_p = 4'b1000; cur_b = 4'b0010; cur_l = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 14) begin
        digits_in = 16'h789C; dp_in = 4'b1000; blank_in = 4'b0010; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      e = exp_q.pop_front();
      checks++;
      if ({seg, dp, an} !== e) begin
        errors++;
        $display("FAIL boundary_load cycle=%0d got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                 k, seg, dp, an, e[11:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    wait_fs("reset_mid");
    digits_in = 16'h8888; dp_in = 4'hF; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg, dp, an, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_immediate got seg=%b dp=%b an=%b fs=%b expected 1111111 1 1111 0",
               seg, dp, an, frame_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur_d = 16'h0000; cur_p = 4'h0; cur_b = 4'hF; cur_l = 1'b0;
    for (int k = 0; k < 48; k++) exp_q.push_back({7'b1111111, 1'b1, 4'b1111});
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({seg, dp, an} !== e) begin
        errors++;
        $display("FAIL reset_mid_dark cycle=%0d got seg=%b dp=%b an=%b expected seg=%b dp=%b an=%b",
                 k, seg, dp, an, e[11:5], e[4], e[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load("basic_12AF", 16'h12AF, 4'b0100, 4'b0000, 1'b0);
    test_load("lz_0050", 16'h0050, 4'b0000, 4'b0000, 1'b1);
    test_two_loads();
    test_boundary_load();
    test_reset_mid();
    test_load("after_reset_E0D7", 16'hE0D7, 4'b0011, 4'b0000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port load, input, 1, one-cycle strobe capturing digits_in, dp_in, blank_in and lz_en.
REQ-006 Port digits_in, input, 4*DIGITS, hex nibble per digit; nibble i = digits_in[4i+3:4i], digit 0 least significant.
REQ-007 Port dp_in, input, DIGITS, decimal point request per digit, 1 = lit.
REQ-008 Port blank_in, input, DIGITS, per-digit blank request, 1 = dark.
REQ-009 Port lz_en, input, 1, leading-zero suppression enable.
REQ-010 Port seg, output, 7, segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
REQ-011 Port dp, output, 1, decimal point segment, active-low.
REQ-012 Port an, output, DIGITS, digit enables, active-low; an[i] drives digit i.
REQ-013 Port frame_start, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-014 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-015 The digit index SHALL advance by one on each slot tick, modulo DIGITS; the wrap DIGITS-1 -> 0 is the frame boundary.
REQ-016 frame_start SHALL be high for exactly the one cycle after the frame-boundary edge.
REQ-017 load SHALL copy all inputs into a pending register and set a pending flag; a load while the flag is already set overwrites the pending contents.
REQ-018 At a frame boundary with the flag set, pending contents SHALL move to the active register and the flag SHALL clear.
REQ-019 A load coinciding with a frame boundary SHALL apply the previous pending contents, capture the new values into pending, and leave the flag set.
REQ-020 Active contents SHALL change only at frame boundaries; no partial-frame update is permitted.
REQ-021 seg, dp and an SHALL be registered, one cycle behind the index and prescaler.
REQ-022 Guard interval: while the prescaler equals 0, an SHALL be all ones, to prevent ghosting.
REQ-023 Outside the guard interval, an SHALL have exactly one zero, at the current index, unless that digit is blanked.
REQ-024 Glyph table, hex nibble -> seg: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111.
REQ-025 Glyph table, continued: 8:0000000, 9:0001100, A:0001000, b:1100000, c:1110010, d:1000010, E:0110000, F:0111000.
REQ-026 A blanked digit SHALL drive an all ones, seg 1111111 and dp 1 for its whole slot.
REQ-027 With lz_en active, digit i>0 SHALL be suppressed when it and every more-significant digit are 0.
REQ-028 A suppressed digit SHALL output seg 1111111, with an and dp driven normally.
REQ-029 Digit 0 SHALL never be suppressed.
REQ-030 dp SHALL equal the inverse of the active dp bit for the current digit.

Reset
REQ-031 While rst_n = 0: prescaler 0, index 0, pending flag 0, active digits 0, active dp 0, active blank all ones, active lz_en 0.
REQ-032 While rst_n = 0: seg 1111111, dp 1, an all ones, frame_start 0.
REQ-033 Deassertion SHALL be synchronised internally; the first slot starts at prescaler 0, index 0.
REQ-034 Reset mid-frame SHALL discard pending data; the display stays dark until a load followed by a frame boundary.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-035 Reset then idle 40 cycles -> an = 1111 throughout; frame_start pulses every 16 cycles.
REQ-036 load digits_in=16'h12AF, blank_in=0, dp_in=4'b0100 -> no change before the next frame_start.
REQ-037 Same stimulus, following frame -> digit 0 seg 0111000, digit 1 seg 0001000, digit 2 seg 0010010 with dp 0, digit 3 seg 1001111; each an low for 3 of 4 slot cycles.
REQ-038 load digits_in=16'h0050, lz_en=1 -> digits 3 and 2 seg 1111111; digit 1 shows 5; digit 0 shows 0.
REQ-039 Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is ever displayed.
REQ-040 load on the frame-boundary cycle -> prior pending applied, new value applied one frame later.
REQ-041 rst_n low mid-slot with pending set -> immediate dark outputs; after release, no stale data appears.
